// File: rtl/riscv_imem_loader.sv
// -----------------------------------------------------------------------------
// riscv_imem_loader
//
// Boot-time program loader. Receives a byte stream over a valid/ready
// handshake. The frame is a 4-byte little-endian word count N followed by
// N little-endian 32-bit words. Each word is written to the RAM write port.
// The core is held in reset until the whole image has been written.
//
// Optional feature: define RISCV_LOADER_CHECKSUM_EN to require a trailing
// checksum byte. That byte is the mod-256 sum of all data bytes; the header
// bytes are not included in the sum.
//
// Ports:
//   clk          system clock
//   x_reset      asynchronous active-low reset
//   restart      synchronous pulse: abort any load, wait for a new header
//   rx_valid     byte available
//   rx_data      byte value
//   rx_ready     loader accepts the byte this cycle
//   mem_we       RAM write strobe, one cycle per word
//   mem_addr     RAM byte address
//   mem_wdata    RAM write data
//   core_x_reset active-low core reset (0 holds the core)
//   load_done    image loaded and core released
//   load_err     load failed, core stays held
// -----------------------------------------------------------------------------
module riscv_imem_loader #(
    parameter int          ADDR_W         = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        x_reset,
    input  logic        restart,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_x_reset,
    output logic        load_done,
    output logic        load_err
);

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_DATA = 3'd1,
        ST_DONE = 3'd2,
        ST_ERR  = 3'd3
`ifdef RISCV_LOADER_CHECKSUM_EN
        , ST_CSUM = 3'd4
`endif
    } state_t;

    // State entered once the last data word (or an empty header) is taken.
`ifdef RISCV_LOADER_CHECKSUM_EN
    localparam state_t ST_TAIL = ST_CSUM;
`else
    localparam state_t ST_TAIL = ST_DONE;
`endif

    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    state_t            state_r;
    state_t            state_s;
    logic [1:0]        byte_cnt_r;
    logic [23:0]       shift_r;
    logic [ADDR_W:0]   idx_r;
    logic [ADDR_W:0]   n_r;
    logic [31:0]       tmo_cnt_r;
`ifdef RISCV_LOADER_CHECKSUM_EN
    logic [7:0]        sum_r;
`endif

    logic              ready_s;
    logic              accept_s;
    logic              word_done_s;
    logic              tmo_run_s;
    logic              tmo_hit_s;
    logic              last_word_s;
    logic [31:0]       assembled_s;

    // Handshake, byte assembly and timeout decode.
    always_comb begin
        ready_s   = 1'b0;
        tmo_run_s = 1'b0;
        case (state_r)
            ST_HDR: begin
                ready_s   = 1'b1;
                // Idle before the first header byte never times out.
                tmo_run_s = (byte_cnt_r != 2'd0);
            end
            ST_DATA: begin
                ready_s   = 1'b1;
                tmo_run_s = 1'b1;
            end
`ifdef RISCV_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                ready_s   = 1'b1;
                tmo_run_s = 1'b1;
            end
`endif
            default: begin
                ready_s   = 1'b0;
                tmo_run_s = 1'b0;
            end
        endcase
        // A restart cycle never consumes a byte.
        rx_ready    = ready_s && !restart;
        accept_s    = rx_valid && rx_ready;
        assembled_s = {rx_data, shift_r};
        word_done_s = accept_s && (byte_cnt_r == 2'd3);
        tmo_hit_s   = tmo_run_s && !accept_s && (tmo_cnt_r == TMO_LAST);
        last_word_s = ((idx_r + (ADDR_W+1)'(1)) == n_r);
    end

    // Next-state decision; restart overrides everything else.
    always_comb begin
        state_s = state_r;
        if (restart) begin
            state_s = ST_HDR;
        end else begin
            case (state_r)
                ST_HDR: begin
                    if (tmo_hit_s) begin
                        state_s = ST_ERR;
                    end else if (word_done_s) begin
                        if (assembled_s == 32'd0) begin
                            state_s = ST_TAIL;
                        end else if ({1'b0, assembled_s} > MAX_WORDS) begin
                            state_s = ST_ERR;
                        end else begin
                            state_s = ST_DATA;
                        end
                    end else begin
                        state_s = ST_HDR;
                    end
                end
                ST_DATA: begin
                    if (tmo_hit_s) begin
                        state_s = ST_ERR;
                    end else if (word_done_s && last_word_s) begin
                        state_s = ST_TAIL;
                    end else begin
                        state_s = ST_DATA;
                    end
                end
`ifdef RISCV_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (tmo_hit_s) begin
                        state_s = ST_ERR;
                    end else if (accept_s) begin
                        state_s = (rx_data == sum_r) ? ST_DONE : ST_ERR;
                    end else begin
                        state_s = ST_CSUM;
                    end
                end
`endif
                ST_DONE: state_s = ST_DONE;
                ST_ERR:  state_s = ST_ERR;
                default: state_s = ST_ERR;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            state_r <= ST_HDR;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            byte_cnt_r   <= 2'd0;
            shift_r      <= 24'd0;
            idx_r        <= '0;
            n_r          <= '0;
            tmo_cnt_r    <= 32'd0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= 32'd0;
            core_x_reset <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
`ifdef RISCV_LOADER_CHECKSUM_EN
            sum_r        <= 8'd0;
`endif
        end else if (restart) begin
            byte_cnt_r   <= 2'd0;
            shift_r      <= 24'd0;
            idx_r        <= '0;
            n_r          <= '0;
            tmo_cnt_r    <= 32'd0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= 32'd0;
            core_x_reset <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
`ifdef RISCV_LOADER_CHECKSUM_EN
            sum_r        <= 8'd0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (accept_s) begin
                byte_cnt_r <= byte_cnt_r + 2'd1;
                shift_r    <= assembled_s[31:8];
                tmo_cnt_r  <= 32'd0;
            end else if (tmo_run_s) begin
                tmo_cnt_r  <= tmo_cnt_r + 32'd1;
            end else begin
                tmo_cnt_r  <= 32'd0;
            end
            if (word_done_s && (state_r == ST_HDR)) begin
                n_r   <= assembled_s[ADDR_W:0];
                idx_r <= '0;
            end else if (word_done_s && (state_r == ST_DATA)) begin
                mem_we    <= 1'b1;
                mem_addr  <= BASE_ADDR + (32'(idx_r) << 2);
                mem_wdata <= assembled_s;
                idx_r     <= idx_r + (ADDR_W+1)'(1);
            end
`ifdef RISCV_LOADER_CHECKSUM_EN
            if (accept_s && (state_r == ST_DATA)) begin
                sum_r <= sum_r + rx_data;
            end
`endif
            load_done    <= (state_s == ST_DONE);
            load_err     <= (state_s == ST_ERR);
            // Release one cycle after DONE entry so the last write has landed.
            core_x_reset <= (state_r == ST_DONE);
        end
    end

endmodule

// File: tb/tb_riscv_imem_loader.sv
module tb_riscv_imem_loader;

    localparam int          ADDR_W = 10;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int          TMO    = 40;
`ifdef RISCV_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        x_reset = 1'b0;
    logic        restart = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_x_reset;
    logic        load_done;
    logic        load_err;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    int          obs_cyc[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int   done_rise = -1;
    int   core_rise = -1;
    logic prev_done = 1'b0;
    logic prev_core = 1'b0;

    riscv_imem_loader #(
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .x_reset(x_reset), .restart(restart),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_x_reset(core_x_reset), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write and rising-edge monitor, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1) begin
            obs_cyc.push_back(cyc);
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_wdata);
        end
        if (load_done === 1'b1 && prev_done == 1'b0) done_rise = cyc;
        if (core_x_reset === 1'b1 && prev_core == 1'b0) core_rise = cyc;
        prev_done = load_done;
        prev_core = core_x_reset;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        rx_valid = 1'b0;
        restart  = 1'b1;
        @(negedge clk);
        restart  = 1'b0;
    endtask

    // Present one byte after 'gap' idle cycles; acc = cycle of the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
        int tries;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        tries = 0;
        while (rx_ready !== 1'b1 && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (rx_ready !== 1'b1) begin
            check_eq("rx_ready_stall", 32'(rx_ready), 32'd1);
            rx_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            rx_valid = 1'b0;
        end
    endtask

    function automatic int pick_gap(input bit rand_gap);
        if (!rand_gap) return 0;
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(1, 5));
        return 0;
    endfunction

    // Send a whole frame and compare against the frame-level expectation.
    task automatic run_frame(input int n, input logic [31:0] words[$],
                             input bit do_restart, input bit rand_gap, input bit bad_csum);
        int base_idx;
        int acc;
        int last_acc;
        int wcyc[$];
        int exp_wr;
        bit over;
        bit exp_err;
        logic [7:0] sum;
        logic [7:0] b;
        logic [31:0] hdr;
        hdr = 32'(n);
        sum = 8'd0;
        over = (n > (1 << ADDR_W));
        if (do_restart) pulse_restart();
        base_idx = obs_addr.size();
        for (int i = 0; i < 4; i++) begin
            b = hdr[8*i +: 8];
            send_byte(b, pick_gap(rand_gap), acc);
        end
        last_acc = acc;
        if (!over) begin
            for (int k = 0; k < n; k++) begin
                for (int i = 0; i < 4; i++) begin
                    b = words[k][8*i +: 8];
                    sum = sum + b;
                    send_byte(b, pick_gap(rand_gap), acc);
                    if (i == 3) wcyc.push_back(acc);
                    last_acc = acc;
                end
            end
            if (CSUM_EN) begin
                send_byte(bad_csum ? sum + 8'd1 : sum, pick_gap(rand_gap), acc);
                last_acc = acc;
            end
        end
        repeat (4) @(posedge clk);
        #1;
        exp_wr  = over ? 0 : n;
        exp_err = over || (CSUM_EN && bad_csum);
        check_eq("wr_count", 32'(obs_addr.size() - base_idx), 32'(exp_wr));
        for (int k = 0; k < exp_wr; k++) begin
            if (base_idx + k < obs_addr.size()) begin
                check_eq("wr_addr", obs_addr[base_idx+k], BASE + 32'(4*k));
                check_eq("wr_data", obs_data[base_idx+k], words[k]);
                check_eq("wr_cycle", 32'(obs_cyc[base_idx+k]), 32'(wcyc[k]));
            end
        end
        check_eq("rx_ready_end", 32'(rx_ready), 32'd0);
        check_eq("load_err", 32'(load_err), 32'(exp_err));
        check_eq("load_done", 32'(load_done), 32'(!exp_err));
        check_eq("core_x_reset", 32'(core_x_reset), 32'(!exp_err));
        if (!exp_err) begin
            check_eq("done_rise_cyc", 32'(done_rise), 32'(last_acc));
            check_eq("core_rise_cyc", 32'(core_rise), 32'(last_acc + 1));
        end
    endtask

    initial begin
        logic [31:0] wq[$];
        int acc;
        int base_idx;
        int n;

        // Reset state, both while held and right after release.
        repeat (3) @(negedge clk);
        check_eq("rst_rx_ready", 32'(rx_ready), 32'd1);
        check_eq("rst_core", 32'(core_x_reset), 32'd0);
        x_reset = 1'b1;
        #1;
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_addr", mem_addr, BASE);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_load_done", 32'(load_done), 32'd0);
        check_eq("rst_load_err", 32'(load_err), 32'd0);

        // Directed two-word program, back-to-back.
        wq = {32'h0010_0513, 32'h0000_006F};
        run_frame(2, wq, 1'b0, 1'b0, 1'b0);

        // Empty image.
        wq = {};
        run_frame(0, wq, 1'b1, 1'b0, 1'b0);

        // Oversized header 2^ADDR_W+1 words.
        run_frame((1 << ADDR_W) + 1, wq, 1'b1, 1'b0, 1'b0);

        // Largest allowed count is not rejected at the header.
        pulse_restart();
        n = 1 << ADDR_W;
        for (int i = 0; i < 4; i++) send_byte(8'(n >> (8*i)), 0, acc);
        @(posedge clk); #1;
        check_eq("max_hdr_no_err", 32'(load_err), 32'd0);
        check_eq("max_hdr_ready", 32'(rx_ready), 32'd1);

        // Timeout: 3 bytes of a word then silence.
        pulse_restart();
        base_idx = obs_addr.size();
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'd1 : 8'd0, 0, acc);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0, acc);
        repeat (TMO - 1) @(posedge clk);
        #1;
        check_eq("tmo_before", 32'(load_err), 32'd0);
        @(posedge clk);
        #1;
        check_eq("tmo_at", 32'(load_err), 32'd1);
        check_eq("tmo_ready", 32'(rx_ready), 32'd0);
        check_eq("tmo_core", 32'(core_x_reset), 32'd0);
        check_eq("tmo_no_wr", 32'(obs_addr.size() - base_idx), 32'd0);
        wq = {$urandom};
        run_frame(1, wq, 1'b1, 1'b0, 1'b0);

        // Restart together with a valid byte during word 3 of 5.
        pulse_restart();
        base_idx = obs_addr.size();
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'd5 : 8'd0, 0, acc);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0, acc);
        @(negedge clk);
        restart  = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        #1;
        check_eq("rst_cycle_ready", 32'(rx_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("restart_we", 32'(mem_we), 32'd0);
        check_eq("restart_core", 32'(core_x_reset), 32'd0);
        @(negedge clk);
        restart  = 1'b0;
        rx_valid = 1'b0;
        check_eq("restart_prior_wr", 32'(obs_addr.size() - base_idx), 32'd2);
        wq = {$urandom, $urandom, $urandom};
        run_frame(3, wq, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-load discards the partial word.
        pulse_restart();
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'd3 : 8'd0, 0, acc);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0, acc);
        @(negedge clk);
        #2;
        x_reset = 1'b0;
        #1;
        check_eq("arst_mem_addr", mem_addr, BASE);
        check_eq("arst_mem_wdata", mem_wdata, 32'd0);
        check_eq("arst_rx_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);
        x_reset = 1'b1;
        wq = {$urandom, $urandom};
        run_frame(2, wq, 1'b0, 1'b1, 1'b0);

        // Randomized frames with random inter-byte gaps.
        for (int f = 0; f < 6; f++) begin
            n = int'($urandom_range(1, 6));
            wq = {};
            for (int k = 0; k < n; k++) wq.push_back($urandom);
            run_frame(n, wq, 1'b1, 1'b1, 1'b0);
        end

        // Checksum accept and reject (only meaningful with the feature on).
        if (CSUM_EN) begin
            wq = {32'hDDCC_BBAA};
            run_frame(1, wq, 1'b1, 1'b0, 1'b0);
            run_frame(1, wq, 1'b1, 1'b0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
